alu_arbiter: RTL and testbench

- Shares one 4-bit `alu` datapath instance between two requesters. Arbitration is round-robin.
- Each request carries an opcode and two operands. The block latches and drives them onto the ALU select/operand lines, waits for settle, captures the 5-bit result and returns it to the granted requester over a valid/ready handshake.
- Sits between the requesting units and the combinational `alu`. One transaction is in flight at a time.

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU between two requesters.
// One transaction is in flight at a time: accept, hold operands to settle, capture, respond.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [2:0] req_op0,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_b0,
    input  logic [2:0] req_op1,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b1,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [4:0] rsp_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_s0,
    output logic       alu_s1,
    output logic       alu_s3,
    input  logic [4:0] alu_out,
    output logic       busy,
    output logic [7:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] result_q, result_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] ops_done_q, ops_done_d;
    logic       pick_s;
    logic [1:0] req_ready_s;

    // Next-state, arbitration and datapath latch selection
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        sel_d        = sel_q;
        ops_done_d   = ops_done_q;
        pick_s       = 1'b0;
        req_ready_s  = 2'b00;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // On a tie the requester not served last wins
                    if (req_valid == 2'b11) begin
                        pick_s = ~last_grant_q;
                    end else begin
                        pick_s = req_valid[1];
                    end
                    req_ready_s = pick_s ? 2'b10 : 2'b01;
                    gnt_d       = pick_s;
                    alu_a_d     = pick_s ? req_a1  : req_a0;
                    alu_b_d     = pick_s ? req_b1  : req_b0;
                    sel_d       = pick_s ? req_op1 : req_op0;
                    cnt_d       = SETTLE_INIT;
                    state_d     = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = alu_out;
                    state_d  = RESP;
                end else begin
                    state_d = SETTLE;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    last_grant_d = gnt_q;
                    ops_done_d   = ops_done_q + 8'd1;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            result_q     <= 5'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            sel_q        <= 3'd0;
            ops_done_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            sel_q        <= sel_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = (state_q == RESP) ? result_q : 5'd0;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s3    = sel_q[2];
    assign alu_s0    = sel_q[1];
    assign alu_s1    = sel_q[0];
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 1-cycle-settle instance for directed and random traffic,
// and a 4-cycle-settle instance for the mid-transaction reset scenario.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural 4-bit ALU: bit 4 is carry (add/inc) or borrow-not (sub/dec)
    function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int unsigned ua, ub, r;
        ua = a;
        ub = b;
        case (op)
            3'd0:    r = ua + ub;
            3'd1:    r = ua + 16 - ub;
            3'd2:    r = ua + 1;
            3'd3:    r = ua + 15;
            3'd4:    r = ua & ub;
            3'd5:    r = ua | ub;
            3'd6:    r = ua ^ ub;
            default: r = ua / 2;
        endcase
        return r[4:0];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instance with SETTLE_CYCLES = 1
    logic       rst;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0] op0, op1;
    logic [3:0] a0, b0, a1, b1, alu_a, alu_b;
    logic [4:0] rsp_data, alu_out;
    logic       alu_s0, alu_s1, alu_s3, busy;
    logic [7:0] ops_done;

    assign alu_out = alu_ref({alu_s3, alu_s0, alu_s1}, alu_a, alu_b);

    alu_arbiter #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(op0), .req_a0(a0), .req_b0(b0), .req_op1(op1), .req_a1(a1), .req_b1(b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s3(alu_s3),
        .alu_out(alu_out), .busy(busy), .ops_done(ops_done)
    );

    // Instance with SETTLE_CYCLES = 4
    logic       rst4;
    logic [1:0] req_valid4, req_ready4, rsp_valid4, rsp_ready4;
    logic [2:0] op0_4, op1_4;
    logic [3:0] a0_4, b0_4, a1_4, b1_4, alu_a4, alu_b4;
    logic [4:0] rsp_data4, alu_out4;
    logic       alu_s0_4, alu_s1_4, alu_s3_4, busy4;
    logic [7:0] ops_done4;

    assign alu_out4 = alu_ref({alu_s3_4, alu_s0_4, alu_s1_4}, alu_a4, alu_b4);

    alu_arbiter #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_op0(op0_4), .req_a0(a0_4), .req_b0(b0_4), .req_op1(op1_4), .req_a1(a1_4), .req_b1(b1_4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_s0(alu_s0_4), .alu_s1(alu_s1_4), .alu_s3(alu_s3_4),
        .alu_out(alu_out4), .busy(busy4), .ops_done(ops_done4)
    );

    // Reference model state: who was served last, and how many transactions completed
    int model_last = 1;
    int model_ops  = 0;

    // One transaction on u_dut. Entered at a negedge in IDLE with requests already driven;
    // returns at the negedge of the following IDLE cycle.
    task automatic txn(input int stall, input bit keep);
        logic       g;
        logic [2:0] eop;
        logic [3:0] ea, eb;
        logic [4:0] er;
        logic [1:0] onehot;
        #1;
        if (req_valid == 2'b11) g = (model_last == 0);
        else                    g = req_valid[1];
        eop    = g ? op1 : op0;
        ea     = g ? a1 : a0;
        eb     = g ? b1 : b0;
        er     = alu_ref(eop, ea, eb);
        onehot = g ? 2'b10 : 2'b01;
        chk("req_ready_grant", req_ready, onehot);
        chk("busy_idle", busy, 1'b0);
        @(posedge clk); #1;
        if (keep) begin
            if (g) begin op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom); end
            else   begin op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom); end
        end else begin
            req_valid = 2'b00;
        end
        @(negedge clk);
        chk("busy_settle", busy, 1'b1);
        chk("rsp_valid_settle", rsp_valid, 2'b00);
        chk("req_ready_settle", req_ready, 2'b00);
        chk("alu_sel", {alu_s3, alu_s0, alu_s1}, eop);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        @(posedge clk); #1;
        rsp_ready = ~onehot;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("rsp_valid_stall", rsp_valid, onehot);
            chk("rsp_data_stall", rsp_data, er);
            chk("req_ready_stall", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("rsp_valid", rsp_valid, onehot);
        chk("rsp_data", rsp_data, er);
        @(posedge clk); #1;
        rsp_ready  = 2'b00;
        model_last = g;
        model_ops++;
        @(negedge clk);
        chk("rsp_valid_after", rsp_valid, 2'b00);
        chk("rsp_data_after", rsp_data, 5'd0);
        chk("busy_after", busy, 1'b0);
        chk("ops_done", ops_done, model_ops[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        op0 = 3'd0; a0 = 4'd0; b0 = 4'd0; op1 = 3'd0; a1 = 4'd0; b1 = 4'd0;
        rst4 = 1'b1; req_valid4 = 2'b00; rsp_ready4 = 2'b00;
        op0_4 = 3'd0; a0_4 = 4'd0; b0_4 = 4'd0; op1_4 = 3'd0; a1_4 = 4'd0; b1_4 = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk("rst_alu_a", alu_a, 4'd0);
        chk("rst_alu_b", alu_b, 4'd0);
        chk("rst_alu_sel", {alu_s3, alu_s0, alu_s1}, 3'd0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data", rsp_data, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ops_done", ops_done, 8'd0);
        chk("rst_req_ready", req_ready, 2'b00);

        // Directed arithmetic ops
        req_valid = 2'b01; op0 = 3'b000; a0 = 4'b1011; b0 = 4'b1111; txn(0, 1'b0);
        req_valid = 2'b10; op1 = 3'b001; a1 = 4'b0101; b1 = 4'b0011; txn(0, 1'b0);
        req_valid = 2'b10; op1 = 3'b011; a1 = 4'b0000; b1 = 4'b0000; txn(0, 1'b0);
        req_valid = 2'b10; op1 = 3'b010; a1 = 4'b1111; b1 = 4'b0000; txn(0, 1'b0);
        // Logic ops
        for (int k = 4; k < 8; k++) begin
            req_valid = 2'b01; op0 = 3'(k); a0 = 4'b1011; b0 = 4'b1111; txn(0, 1'b0);
        end

        // Continuous tie from reset, with backpressure on the second response
        rst = 1'b1; req_valid = 2'b11;
        @(posedge clk); #1 rst = 1'b0;
        model_last = 1; model_ops = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) txn((k == 1) ? 3 : 0, 1'b1);
        req_valid = 2'b00;

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            req_valid = 2'($urandom_range(1, 3));
            op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
            op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            txn(int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset during SETTLE on the 4-cycle instance
        @(negedge clk);
        req_valid4 = 2'b11; op0_4 = 3'b000; a0_4 = 4'd3; b0_4 = 4'd4; op1_4 = 3'b110; a1_4 = 4'd9; b1_4 = 4'd5;
        #1 chk("r4_req_ready_first", req_ready4, 2'b01);
        @(posedge clk); #1 req_valid4 = 2'b00;
        repeat (2) begin
            @(negedge clk);
            chk("r4_busy_settle", busy4, 1'b1);
            chk("r4_rsp_valid_settle", rsp_valid4, 2'b00);
            @(posedge clk); #1;
        end
        rst4 = 1'b1;
        @(posedge clk); #1 rst4 = 1'b0;
        @(negedge clk);
        chk("r4_busy_rst", busy4, 1'b0);
        chk("r4_ops_rst", ops_done4, 8'd0);
        chk("r4_rsp_data_rst", rsp_data4, 5'd0);
        chk("r4_alu_a_rst", alu_a4, 4'd0);
        repeat (6) begin
            @(negedge clk);
            chk("r4_no_rsp", rsp_valid4, 2'b00);
        end
        req_valid4 = 2'b11; rsp_ready4 = 2'b01;
        #1 chk("r4_tie_after_rst", req_ready4, 2'b01);
        @(posedge clk); #1 req_valid4 = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("r4_rsp_valid_wait", rsp_valid4, 2'b00);
            @(posedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("r4_rsp_valid", rsp_valid4, 2'b01);
        chk("r4_rsp_data", rsp_data4, alu_ref(3'b000, 4'd3, 4'd4));
        @(posedge clk); #1 rsp_ready4 = 2'b00;
        @(negedge clk);
        chk("r4_ops_done", ops_done4, 8'd1);
        chk("r4_busy_after", busy4, 1'b0);
        req_valid4 = 2'b11;
        #1 chk("r4_tie_second", req_ready4, 2'b10);
        req_valid4 = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
